dram_read_res_queue: RTL and testbench
======================================

DRAM_READ_RES_QUEUE -- requirements
Module: dram_read_res_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, response FIFO entries; power of two, at least 2.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port dram_be_res_valid  input  1  DRAM read response present.
REQ-005 SHALL have port dram_be_res_id  input  DRAM_ID_WIDTH  tag of the response.
REQ-006 SHALL have port dram_be_res_data  input  DRAM_DATA_WIDTH  response payload.
REQ-007 SHALL have port dram_be_res_ready  output  1  queue can accept a response this cycle.
REQ-008 SHALL have port req_issue  input  1  a read request was accepted by DRAM this cycle (be_dram_req valid and be_dram_req_ready).
REQ-009 SHALL have port req_issue_id  input  DRAM_ID_WIDTH  tag of the issued request.
REQ-010 SHALL have port be_res_valid  output  1  head entry available to the scratchpad writer.
REQ-011 SHALL have port be_res  output  dram_read_res_t  head entry {id, data}.
REQ-012 SHALL have port be_res_ready  input  1  scratchpad writer consumes the head.
REQ-013 SHALL have port credit_avail  output  1  another read request may be issued.
REQ-014 SHALL have port outstanding_cnt  output  $clog2(DEPTH)+1  requests issued but not yet delivered.
REQ-015 SHALL have port proto_error  output  1  sticky protocol-violation flag.

Function
REQ-016 Push SHALL occur when dram_be_res_valid and dram_be_res_ready are both high. The entry {id, data} is written at the tail.
REQ-017 Pop SHALL occur when be_res_valid and be_res_ready are both high. The head advances.
REQ-018 dram_be_res_ready SHALL equal not-full. There is no push into a full FIFO, even when a pop occurs in the same cycle.
REQ-019 be_res_valid SHALL equal not-empty. There is no bypass: push-to-be_res_valid latency is exactly 1 cycle.
REQ-020 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the occupancy unchanged.
REQ-021 Pointers SHALL be $clog2(DEPTH)+1 bits with a wrap bit; wrap-around is modulo DEPTH.
REQ-022 Full SHALL be when the indices match and the wrap bits differ; empty SHALL be when the full pointers are equal.
REQ-023 outstanding_cnt SHALL behave as follows:
- +1 on req_issue;
- -1 on pop;
- unchanged when both occur in the same cycle.
REQ-024 credit_avail SHALL equal (outstanding_cnt < DEPTH). This guarantees every issued request has FIFO space.
REQ-025 A req_issue while credit_avail is low SHALL set proto_error and SHALL NOT increment outstanding_cnt.
REQ-026 A pending bitmap of 2**DRAM_ID_WIDTH bits SHALL be maintained:
- req_issue sets bit req_issue_id;
- push clears bit dram_be_res_id.
REQ-027 A push whose id bit is not pending SHALL set proto_error. The entry SHALL still be accepted and forwarded.
REQ-028 A req_issue whose id bit is pending and not cleared by a push in the same cycle SHALL set proto_error.
REQ-029 A req_issue and a push with the same id in one cycle SHALL leave that bit set and SHALL raise no error.
REQ-030 Once set, proto_error SHALL remain high until reset.
REQ-031 be_res SHALL be driven from the head entry. Its value is don't-care while be_res_valid is low.

Reset
REQ-032 On RST high, asynchronously:
- pointers, outstanding_cnt, pending bitmap and proto_error SHALL clear;
- dram_be_res_ready SHALL go to 1, be_res_valid to 0 and credit_avail to 1.
REQ-033 Reset mid-transfer SHALL discard all buffered entries and outstanding state. No push or pop occurs in a cycle in which RST is high.
REQ-034 FIFO data storage SHALL NOT require reset.

Structure
REQ-035 dram_read_res_t {DRAM_ID_WIDTH id; DRAM_DATA_WIDTH data} and DRAM_DATA_WIDTH SHALL be added to scpad_types_pkg, alongside the existing DRAM_ID_WIDTH.
REQ-036 Storage and pointers SHALL be a sub-module dram_res_fifo (parameter DEPTH, type dram_read_res_t). Credit, bitmap and error logic SHALL stay in the top module.

Verification
REQ-037 Reset, then issue id 3, then push id 3 with data 0xA5A5 -> be_res_valid 1 cycle later; id=3 and data=0xA5A5 at the head; outstanding_cnt goes 1 then 0 after pop; proto_error stays 0.
REQ-038 DEPTH=4: issue ids 0-3, push 4 responses with be_res_ready low -> dram_be_res_ready 0 and credit_avail 0; a fifth req_issue sets proto_error and outstanding_cnt stays 4.
REQ-039 Full FIFO, then pop and push in the same cycle -> push not accepted that cycle; one pop later the push is accepted; order 0,1,2,3,new is preserved.
REQ-040 Stream 10 responses with be_res_ready toggling every cycle -> pointers wrap twice; output order equals input order; there is no loss and no duplication.
REQ-041 Push id 5 with no prior issue -> proto_error 1 and the entry is still delivered. A same-cycle issue plus push of id 2 (2 pending) -> no error, and bit 2 remains set.
REQ-042 Assert RST with 3 entries buffered -> be_res_valid 0, outstanding_cnt 0 and proto_error 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/scpad_types_pkg.sv
// Shared scratchpad/DRAM back-end types: tag and payload widths plus the read-response entry.
package scpad_types_pkg;

  localparam int unsigned DRAM_ID_WIDTH   = 3;
  localparam int unsigned DRAM_DATA_WIDTH = 16;

  typedef struct packed {
    logic [DRAM_ID_WIDTH-1:0]   id;
    logic [DRAM_DATA_WIDTH-1:0] data;
  } dram_read_res_t;

endpackage

// File: rtl/dram_read_res_queue_if.sv
// Bundle of the DRAM response, request-issue and scratchpad-writer signals around the queue.
interface dram_read_res_queue_if #(
  parameter int unsigned DEPTH = 4
);
  import scpad_types_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                       dram_be_res_valid;
  logic [DRAM_ID_WIDTH-1:0]   dram_be_res_id;
  logic [DRAM_DATA_WIDTH-1:0] dram_be_res_data;
  logic                       dram_be_res_ready;
  logic                       req_issue;
  logic [DRAM_ID_WIDTH-1:0]   req_issue_id;
  logic                       be_res_valid;
  dram_read_res_t             be_res;
  logic                       be_res_ready;
  logic                       credit_avail;
  logic [CW-1:0]              outstanding_cnt;
  logic                       proto_error;

  // Queue side
  modport slave (
    input  dram_be_res_valid, dram_be_res_id, dram_be_res_data,
    input  req_issue, req_issue_id, be_res_ready,
    output dram_be_res_ready, be_res_valid, be_res,
    output credit_avail, outstanding_cnt, proto_error
  );

  // Environment side (DRAM, request issuer, scratchpad writer)
  modport master (
    output dram_be_res_valid, dram_be_res_id, dram_be_res_data,
    output req_issue, req_issue_id, be_res_ready,
    input  dram_be_res_ready, be_res_valid, be_res,
    input  credit_avail, outstanding_cnt, proto_error
  );

endinterface

// File: rtl/dram_res_fifo.sv
// Wrap-bit pointer FIFO holding DRAM read responses; no bypass, storage is not reset.
module dram_res_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type T = scpad_types_pkg::dram_read_res_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output T     dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  T              mem_q [DEPTH];
  logic          push_c, pop_c;

  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_c  = push_i && !full_o && !rst;
  assign pop_c   = pop_i && !empty_o && !rst;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; the extra MSB distinguishes full from empty
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage, written at the tail
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/dram_read_res_queue.sv
// DRAM read-response queue: buffers responses, grants request credits, tracks tags in flight.
module dram_read_res_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic                  CLK,
  input logic                  RST,
  dram_read_res_queue_if.slave bus
);
  import scpad_types_pkg::*;

  localparam int unsigned CW   = $clog2(DEPTH) + 1;
  localparam int unsigned NIDS = 1 << DRAM_ID_WIDTH;

  logic           full_c, empty_c, push_c, pop_c, credit_c, issue_ok_c;
  dram_read_res_t wr_entry_c, head_c;
  logic [CW-1:0]  outstanding_q, outstanding_d;
  logic [NIDS-1:0] pending_q, pending_d;
  logic           err_q, err_d;

  assign push_c     = bus.dram_be_res_valid && !full_c;
  assign pop_c      = bus.be_res_ready && !empty_c;
  assign credit_c   = (outstanding_q < CW'(DEPTH));
  assign issue_ok_c = bus.req_issue && credit_c;

  assign wr_entry_c.id   = bus.dram_be_res_id;
  assign wr_entry_c.data = bus.dram_be_res_data;

  dram_res_fifo #(
    .DEPTH (DEPTH),
    .T     (dram_read_res_t)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push_i  (push_c),
    .din_i   (wr_entry_c),
    .pop_i   (pop_c),
    .dout_o  (head_c),
    .full_o  (full_c),
    .empty_o (empty_c)
  );

  assign bus.dram_be_res_ready = !full_c;
  assign bus.be_res_valid      = !empty_c;
  assign bus.be_res            = head_c;
  assign bus.credit_avail      = credit_c;
  assign bus.outstanding_cnt   = outstanding_q;
  assign bus.proto_error       = err_q;

  // Credit count, tag bitmap (clear on push, then set on issue) and sticky error detection
  always_comb begin
    outstanding_d = outstanding_q;
    if (issue_ok_c && !pop_c) begin
      outstanding_d = outstanding_q + CW'(1);
    end else if (!issue_ok_c && pop_c && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - CW'(1);
    end

    pending_d = pending_q;
    if (push_c)        pending_d[bus.dram_be_res_id] = 1'b0;
    if (bus.req_issue) pending_d[bus.req_issue_id]   = 1'b1;

    err_d = err_q;
    if (bus.req_issue && !credit_c) err_d = 1'b1;
    if (bus.req_issue && pending_q[bus.req_issue_id] &&
        !(push_c && (bus.dram_be_res_id == bus.req_issue_id))) err_d = 1'b1;
    if (push_c && !pending_q[bus.dram_be_res_id]) err_d = 1'b1;
  end

  // Control state registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      outstanding_q <= '0;
      pending_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      pending_q     <= pending_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_dram_read_res_queue.sv
// Testbench for dram_read_res_queue: directed scenarios plus random traffic against a queue model.
module tb_dram_read_res_queue;
  import scpad_types_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NIDS  = 1 << DRAM_ID_WIDTH;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dram_read_res_queue_if #(.DEPTH(DEPTH)) bus ();

  dram_read_res_queue #(.DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Reference model: response queue contents, credits in use, tags in flight, sticky error
  dram_read_res_t mq[$];
  int             m_out;
  bit             m_pend[NIDS];
  bit             m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ":res_ready"}, 32'(bus.dram_be_res_ready), 32'(mq.size() < DEPTH));
    chk({ctx, ":res_valid"}, 32'(bus.be_res_valid), 32'(mq.size() > 0));
    chk({ctx, ":credit"},    32'(bus.credit_avail), 32'(m_out < DEPTH));
    chk({ctx, ":outst"},     32'(bus.outstanding_cnt), 32'(m_out));
    chk({ctx, ":perr"},      32'(bus.proto_error), 32'(m_err));
    if (mq.size() > 0) begin
      chk({ctx, ":head_id"},   32'(bus.be_res.id), 32'(mq[0].id));
      chk({ctx, ":head_data"}, 32'(bus.be_res.data), 32'(mq[0].data));
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_out = 0;
    m_err = 1'b0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model
  task automatic cycle(input int rv, input int rid, input int rdata,
                       input int iss, input int iid, input int rdy);
    bit push, pop, credit;
    dram_read_res_t e;
    bus.dram_be_res_valid = 1'(rv);
    bus.dram_be_res_id    = DRAM_ID_WIDTH'(rid);
    bus.dram_be_res_data  = DRAM_DATA_WIDTH'(rdata);
    bus.req_issue         = 1'(iss);
    bus.req_issue_id      = DRAM_ID_WIDTH'(iid);
    bus.be_res_ready      = 1'(rdy);
    #1;
    check_outputs("cyc");
    push   = (rv != 0) && (mq.size() < DEPTH);
    pop    = (rdy != 0) && (mq.size() > 0);
    credit = (m_out < DEPTH);
    if (iss != 0 && !credit) m_err = 1'b1;
    if (iss != 0 && m_pend[iid] && !(push && rid == iid)) m_err = 1'b1;
    if (push && !m_pend[rid]) m_err = 1'b1;
    if (pop) void'(mq.pop_front());
    if (push) begin
      e.id   = DRAM_ID_WIDTH'(rid);
      e.data = DRAM_DATA_WIDTH'(rdata);
      mq.push_back(e);
      m_pend[rid] = 1'b0;
    end
    if (iss != 0) begin
      m_pend[iid] = 1'b1;
      if (credit) m_out++;
    end
    if (pop && m_out > 0) m_out--;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.dram_be_res_valid = 1'b0;
    bus.dram_be_res_id    = '0;
    bus.dram_be_res_data  = '0;
    bus.req_issue         = 1'b0;
    bus.req_issue_id      = '0;
    bus.be_res_ready      = 1'b0;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset();
    RST = 1'b1;
    idle_inputs();
    #1;
    model_clear();
    check_outputs("rst_async");
    @(posedge CLK);
    #1;
    check_outputs("rst_held");
    RST = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DEPTH && mq.size() > 0; k++) cycle(0, 0, 0, 0, 0, 1);
  endtask

  // Ten in-order responses with the consumer toggling ready every cycle
  task automatic stream10();
    int n_iss = 0;
    int n_rsp = 0;
    for (int c = 0; c < 80 && !(n_rsp == 10 && mq.size() == 0); c++) begin
      int iss = 0, iid = 0, rv = 0, rid = 0;
      bit acc;
      if (n_iss < 10 && m_out < DEPTH && !m_pend[n_iss % NIDS]) begin
        iss = 1;
        iid = n_iss % NIDS;
      end
      if (n_rsp < n_iss) begin
        rv  = 1;
        rid = n_rsp % NIDS;
      end
      acc = (rv != 0) && (mq.size() < DEPTH);
      cycle(rv, rid, int'($urandom_range(0, 65535)), iss, iid, c % 2);
      if (iss != 0) n_iss++;
      if (acc) n_rsp++;
    end
    chk("stream_empty", 32'(bus.be_res_valid), 32'd0);
    chk("stream_outst", 32'(bus.outstanding_cnt), 32'd0);
    chk("stream_perr",  32'(bus.proto_error), 32'd0);
  endtask

  // Protocol-legal random traffic: issue free tags within credit, answer pending tags
  task automatic random_legal(input int n);
    for (int c = 0; c < n; c++) begin
      int iss = 0, iid = 0, rv = 0, rid = 0, start;
      if (m_out < DEPTH && $urandom_range(0, 1) == 1) begin
        start = int'($urandom_range(0, NIDS - 1));
        for (int k = 0; k < NIDS; k++) begin
          if (iss == 0 && !m_pend[(start + k) % NIDS]) begin
            iss = 1;
            iid = (start + k) % NIDS;
          end
        end
      end
      if ($urandom_range(0, 2) != 0) begin
        start = int'($urandom_range(0, NIDS - 1));
        for (int k = 0; k < NIDS; k++) begin
          if (rv == 0 && m_pend[(start + k) % NIDS]) begin
            rv  = 1;
            rid = (start + k) % NIDS;
          end
        end
      end
      cycle(rv, rid, int'($urandom_range(0, 65535)), iss, iid, int'($urandom_range(0, 1)));
    end
  endtask

  // Unconstrained random traffic including protocol violations
  task automatic random_any(input int n);
    for (int c = 0; c < n; c++) begin
      cycle(int'($urandom_range(0, 1)), int'($urandom_range(0, NIDS - 1)),
            int'($urandom_range(0, 65535)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, NIDS - 1)), int'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    idle_inputs();
    #2;

    // Single issue/response/pop
    do_reset();
    cycle(0, 0, 0, 1, 3, 0);
    chk("t1_outst1", 32'(bus.outstanding_cnt), 32'd1);
    chk("t1_novalid", 32'(bus.be_res_valid), 32'd0);
    cycle(1, 3, 16'hA5A5, 0, 0, 0);
    chk("t1_valid", 32'(bus.be_res_valid), 32'd1);
    chk("t1_id", 32'(bus.be_res.id), 32'd3);
    chk("t1_data", 32'(bus.be_res.data), 32'hA5A5);
    cycle(0, 0, 0, 0, 0, 1);
    chk("t1_outst0", 32'(bus.outstanding_cnt), 32'd0);
    chk("t1_perr", 32'(bus.proto_error), 32'd0);
    cycle(0, 0, 0, 0, 0, 0);

    // Fill to DEPTH, then an over-credit issue
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, i, 0);
    for (int i = 0; i < 4; i++) cycle(1, i, 16'h1000 + i, 0, 0, 0);
    chk("t2_ready0", 32'(bus.dram_be_res_ready), 32'd0);
    chk("t2_credit0", 32'(bus.credit_avail), 32'd0);
    cycle(0, 0, 0, 1, 4, 0);
    chk("t2_perr", 32'(bus.proto_error), 32'd1);
    chk("t2_outst4", 32'(bus.outstanding_cnt), 32'd4);

    // Full FIFO: simultaneous pop and push rejects the push, retried next cycle
    cycle(1, 4, 16'h4444, 0, 0, 1);
    chk("t3_head1", 32'(bus.be_res.id), 32'd1);
    cycle(1, 4, 16'h4444, 0, 0, 0);
    for (int i = 1; i < 4; i++) begin
      chk("t3_order", 32'(bus.be_res.id), 32'(i));
      cycle(0, 0, 0, 0, 0, 1);
    end
    chk("t3_new_id", 32'(bus.be_res.id), 32'd4);
    chk("t3_new_data", 32'(bus.be_res.data), 32'h4444);
    drain();

    // Streaming with pointer wrap
    do_reset();
    stream10();

    // Unrequested tag, then same-cycle issue and response of a pending tag
    do_reset();
    cycle(1, 5, 16'h5555, 0, 0, 0);
    chk("t5_perr", 32'(bus.proto_error), 32'd1);
    chk("t5_delivered", 32'(bus.be_res.data), 32'h5555);
    drain();
    do_reset();
    cycle(0, 0, 0, 1, 2, 0);
    cycle(1, 2, 16'h2222, 1, 2, 0);
    cycle(1, 2, 16'h2323, 0, 0, 0);
    chk("t5_same_id_ok", 32'(bus.proto_error), 32'd0);
    drain();

    // Reset while entries are buffered
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, i, 0);
    for (int i = 0; i < 3; i++) cycle(1, i, 16'h3000 + i, 0, 0, 0);
    chk("t6_valid_before", 32'(bus.be_res_valid), 32'd1);
    do_reset();

    // Random phases
    random_legal(400);
    chk("rand_legal_perr", 32'(bus.proto_error), 32'd0);
    do_reset();
    random_any(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
